div_hilo_seq: RTL

//  Sequencer that sits directly upstream and downstream of the unsigned divider core (divu).

---
 rtl/cpu_pkg.sv | 16 +
 rtl/div_hilo_seq_sign_fix.sv | 14 +
 rtl/div_hilo_seq.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared CPU constants for the HI/LO divide sequencer
package cpu_pkg;

   localparam logic [1:0] DIVSEQ_IDLE = 2'd0;
   localparam logic [1:0] DIVSEQ_CALC = 2'd1;
   localparam logic [1:0] DIVSEQ_FIX  = 2'd2;

   localparam logic [31:0] DIV_ZERO_LO = 32'hFFFF_FFFF;

   typedef enum logic [1:0] {
      ST_IDLE = DIVSEQ_IDLE,
      ST_CALC = DIVSEQ_CALC,
      ST_FIX  = DIVSEQ_FIX
   } divseq_state_t;

endpackage

// File: rtl/div_hilo_seq_sign_fix.sv
// rtl/div_hilo_seq_sign_fix.sv - conditional two's-complement negate
// Used both to take operand magnitudes and to restore result signs.
module sign_fix #(
   parameter int WIDTH = 32
) (
   input  logic [WIDTH-1:0] i_val,
   input  logic             i_neg,
   output logic [WIDTH-1:0] o_val
);

   // Modulo 2^WIDTH: negating the most negative value yields itself.
   assign o_val = i_neg ? (~i_val + WIDTH'(1)) : i_val;

endmodule

// File: rtl/div_hilo_seq.sv
// rtl/div_hilo_seq.sv - DIV/DIVU sequencer around the unsigned divider core
// Owns HI/LO, feeds magnitudes to divu, sign-corrects and commits the result.
module div_hilo_seq
   import cpu_pkg::*;
#(
   parameter int DIV_LATENCY = 2,
   parameter int WIDTH       = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic             is_signed,
   input  logic [WIDTH-1:0] op_a,
   input  logic [WIDTH-1:0] op_b,
   input  logic             mthi,
   input  logic             mtlo,
   input  logic [WIDTH-1:0] wdata,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo,
   output logic             busy,
   output logic             done,
   output logic             div_zero,
   output logic [WIDTH-1:0] div_dividend,
   output logic [WIDTH-1:0] div_divisor,
   output logic             div_ena,
   input  logic [WIDTH-1:0] div_q,
   input  logic [WIDTH-1:0] div_r
);

   divseq_state_t    r_state;
   logic [3:0]       r_cnt;
   logic             r_neg_q;
   logic             r_neg_r;
   logic             r_by_zero;
   logic [WIDTH-1:0] r_raw_a;
   logic [WIDTH-1:0] r_hi;
   logic [WIDTH-1:0] r_lo;
   logic             r_busy;
   logic             r_done;
   logic             r_div_zero;
   logic [WIDTH-1:0] r_dividend;
   logic [WIDTH-1:0] r_divisor;
   logic             r_ena;

   logic [WIDTH-1:0] w_abs_a;
   logic [WIDTH-1:0] w_abs_b;
   logic [WIDTH-1:0] w_q_fix;
   logic [WIDTH-1:0] w_r_fix;

   sign_fix #(.WIDTH(WIDTH)) u_abs_a (
      .i_val (op_a),
      .i_neg (is_signed & op_a[WIDTH-1]),
      .o_val (w_abs_a)
   );

   sign_fix #(.WIDTH(WIDTH)) u_abs_b (
      .i_val (op_b),
      .i_neg (is_signed & op_b[WIDTH-1]),
      .o_val (w_abs_b)
   );

   sign_fix #(.WIDTH(WIDTH)) u_fix_q (
      .i_val (div_q),
      .i_neg (r_neg_q),
      .o_val (w_q_fix)
   );

   sign_fix #(.WIDTH(WIDTH)) u_fix_r (
      .i_val (div_r),
      .i_neg (r_neg_r),
      .o_val (w_r_fix)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state    <= ST_IDLE;
         r_cnt      <= 4'd0;
         r_neg_q    <= 1'b0;
         r_neg_r    <= 1'b0;
         r_by_zero  <= 1'b0;
         r_raw_a    <= '0;
         r_hi       <= '0;
         r_lo       <= '0;
         r_busy     <= 1'b0;
         r_done     <= 1'b0;
         r_div_zero <= 1'b0;
         r_dividend <= '0;
         r_divisor  <= '0;
         r_ena      <= 1'b0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (mthi) r_hi <= wdata;
               if (mtlo) r_lo <= wdata;
               // A same-cycle MTHI/MTLO lands first; the commit overwrites it later.
               if (start) begin
                  r_neg_q    <= is_signed & (op_a[WIDTH-1] ^ op_b[WIDTH-1]);
                  r_neg_r    <= is_signed & op_a[WIDTH-1];
                  r_by_zero  <= (op_b == '0);
                  r_raw_a    <= op_a;
                  r_dividend <= w_abs_a;
                  r_divisor  <= w_abs_b;
                  r_cnt      <= 4'(DIV_LATENCY - 1);
                  r_busy     <= 1'b1;
                  r_ena      <= 1'b1;
                  r_div_zero <= 1'b0;
                  r_state    <= ST_CALC;
               end
            end
            ST_CALC: begin
               if (r_cnt == 4'd0) r_state <= ST_FIX;
               else               r_cnt   <= r_cnt - 4'd1;
            end
            ST_FIX: begin
               // Divide by zero ignores the core and commits fixed values.
               if (r_by_zero) begin
                  r_lo       <= WIDTH'(DIV_ZERO_LO);
                  r_hi       <= r_raw_a;
                  r_div_zero <= 1'b1;
               end else begin
                  r_lo <= w_q_fix;
                  r_hi <= w_r_fix;
               end
               r_done  <= 1'b1;
               r_busy  <= 1'b0;
               r_ena   <= 1'b0;
               r_state <= ST_IDLE;
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign hi           = r_hi;
   assign lo           = r_lo;
   assign busy         = r_busy;
   assign done         = r_done;
   assign div_zero     = r_div_zero;
   assign div_dividend = r_dividend;
   assign div_divisor  = r_divisor;
   assign div_ena      = r_ena;

endmodule
